// File: rtl/im_loader.sv
// im_loader: item-memory writer for the sparse HDC datapath.
// Assembles a valid/ready stream of WORD_W-bit words, least significant word
// first, into NUM_LEVELS level hypervectors. These drive the im1..im10 inputs
// of the level-HV fetch mux.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   start            one-cycle pulse that begins or restarts programming
//   in_data/in_valid word stream input
//   in_ready         combinational: a word is accepted this cycle
//   im1..im10        stored level hypervectors, each committed whole
//   level_idx        entry currently being assembled
//   busy             FSM is in LOAD
//   loaded           all entries written since the last start
module im_loader #(
  parameter int unsigned HV_W       = 64,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned NUM_LEVELS = 10
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [HV_W-1:0]   im1,
  output logic [HV_W-1:0]   im2,
  output logic [HV_W-1:0]   im3,
  output logic [HV_W-1:0]   im4,
  output logic [HV_W-1:0]   im5,
  output logic [HV_W-1:0]   im6,
  output logic [HV_W-1:0]   im7,
  output logic [HV_W-1:0]   im8,
  output logic [HV_W-1:0]   im9,
  output logic [HV_W-1:0]   im10,
  output logic [3:0]        level_idx,
  output logic              busy,
  output logic              loaded
);

  localparam int unsigned WPH   = HV_W / WORD_W;
  localparam int unsigned CNT_W = (WPH > 1) ? $clog2(WPH) : 1;
  localparam int unsigned IDX_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_word_cnt;
  logic [IDX_W-1:0] r_entry_cnt;
  logic [HV_W-1:0]  r_stage;
  logic [HV_W-1:0]  r_im [NUM_LEVELS];
  logic             r_loaded;

  logic             w_accept;
  logic             w_last_word;
  logic             w_last_entry;
  logic [HV_W-1:0]  w_entry;

  // Handshake and counter terminal conditions
  assign in_ready     = (r_state == S_LOAD) && !start;
  assign w_accept     = in_valid && in_ready;
  assign w_last_word  = (r_word_cnt == CNT_W'(WPH - 1));
  assign w_last_entry = (r_entry_cnt == IDX_W'(NUM_LEVELS - 1));

  // Completed entry: staged lower words plus the word arriving now on top
  always_comb begin
    w_entry = r_stage;
    w_entry[HV_W-1 -: WORD_W] = in_data;
  end

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; start takes priority in every state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (start)                                        w_state_nxt = S_LOAD;
        else if (w_accept && w_last_word && w_last_entry) w_state_nxt = S_DONE;
      end
      S_DONE: if (start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, staging register and loaded flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_word_cnt  <= '0;
      r_entry_cnt <= '0;
      r_stage     <= '0;
      r_loaded    <= 1'b0;
    end else if (start) begin
      r_word_cnt  <= '0;
      r_entry_cnt <= '0;
      r_stage     <= '0;
      r_loaded    <= 1'b0;
    end else if (w_accept) begin
      r_stage[int'(r_word_cnt)*WORD_W +: WORD_W] <= in_data;
      if (w_last_word) begin
        r_word_cnt <= '0;
        r_stage    <= '0;
        if (w_last_entry) begin
          r_entry_cnt <= '0;
          r_loaded    <= 1'b1;
        end else begin
          r_entry_cnt <= r_entry_cnt + IDX_W'(1);
        end
      end else begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end
  end

  // Item memory: one whole entry committed on the last word's edge; start does not clear it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned e = 0; e < NUM_LEVELS; e++) r_im[e] <= '0;
    end else if (w_accept && w_last_word) begin
      for (int unsigned e = 0; e < NUM_LEVELS; e++) begin
        if (r_entry_cnt == IDX_W'(e)) r_im[e] <= w_entry;
      end
    end
  end

  assign im1       = r_im[0];
  assign im2       = r_im[1];
  assign im3       = r_im[2];
  assign im4       = r_im[3];
  assign im5       = r_im[4];
  assign im6       = r_im[5];
  assign im7       = r_im[6];
  assign im8       = r_im[7];
  assign im9       = r_im[8];
  assign im10      = r_im[9];
  assign level_idx = r_entry_cnt;
  assign busy      = (r_state == S_LOAD);
  assign loaded    = r_loaded;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: randomized word streams with valid gaps,
// restarts and resets, compared every cycle against a queue-based model,
// plus a few literal expectations.
module tb_im_loader;

  localparam int unsigned HV_W   = 64;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned WPH    = HV_W / WORD_W;
  localparam int unsigned NLV    = 10;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [HV_W-1:0]   im1, im2, im3, im4, im5, im6, im7, im8, im9, im10;
  logic [3:0]        level_idx;
  logic              busy;
  logic              loaded;

  im_loader dut (
    .clk(clk), .nrst(nrst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .im1(im1), .im2(im2), .im3(im3), .im4(im4), .im5(im5),
    .im6(im6), .im7(im7), .im8(im8), .im9(im9), .im10(im10),
    .level_idx(level_idx), .busy(busy), .loaded(loaded)
  );

  always #5 clk = ~clk;

  logic [HV_W-1:0] dut_im [NLV];
  assign dut_im[0] = im1;  assign dut_im[1] = im2;  assign dut_im[2] = im3;
  assign dut_im[3] = im4;  assign dut_im[4] = im5;  assign dut_im[5] = im6;
  assign dut_im[6] = im7;  assign dut_im[7] = im8;  assign dut_im[8] = im9;
  assign dut_im[9] = im10;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=loading, 2=done
  int              m_mode;
  int              m_entry;
  bit              m_loaded;
  logic [HV_W-1:0] m_im [NLV];
  logic [WORD_W-1:0] m_words [$];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode = 0; m_entry = 0; m_loaded = 0;
      m_words.delete();
      for (int i = 0; i < NLV; i++) m_im[i] = '0;
    end else if (start) begin
      m_mode = 1; m_entry = 0; m_loaded = 0;
      m_words.delete();
    end else if (m_mode == 1 && in_valid) begin
      m_words.push_back(in_data);
      if (m_words.size() == WPH) begin
        logic [HV_W-1:0] v;
        v = '0;
        for (int w = 0; w < WPH; w++) v[w*WORD_W +: WORD_W] = m_words[w];
        m_im[m_entry] = v;
        m_words.delete();
        m_entry++;
        if (m_entry == NLV) begin
          m_entry = 0; m_loaded = 1; m_mode = 2;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'((m_mode == 1) && !start));
    chk("busy", 64'(busy), 64'(m_mode == 1));
    chk("loaded", 64'(loaded), 64'(m_loaded));
    chk("level_idx", 64'(level_idx), 64'(m_entry));
    for (int i = 0; i < NLV; i++) chk($sformatf("im%0d", i + 1), dut_im[i], m_im[i]);
  end

  logic [WORD_W-1:0] src [40];

  // Present src[0..n-1] in order; gap is the percent chance of idling a cycle
  task automatic load_words(input int n, input int gap);
    int idx = 0;
    int budget = 0;
    bit acc;
    while (idx < n && budget < 2000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = in_valid ? src[idx] : WORD_W'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    chk("words_accepted", 64'(idx), 64'(n));
  endtask

  task automatic pulse_start(input bit with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = WORD_W'($urandom);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    chk("rst_im1", im1, 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Full back-to-back load with incrementing words
    for (int k = 0; k < 40; k++) src[k] = WORD_W'(k);
    pulse_start(1'b0);
    load_words(40, 0);
    chk("full_im1", im1, 64'h0003_0002_0001_0000);
    chk("full_im10", im10, 64'h0027_0026_0025_0024);
    chk("full_loaded", 64'(loaded), 64'h1);
    chk("full_done_busy", 64'(busy), 64'h0);
    chk("full_done_ready", 64'(in_ready), 64'h0);

    // Reload from DONE with random valid gaps
    pulse_start(1'b0);
    chk("reload_loaded", 64'(loaded), 64'h0);
    chk("reload_im1_kept", im1, 64'h0003_0002_0001_0000);
    load_words(40, 40);
    chk("gap_im1", im1, 64'h0003_0002_0001_0000);
    chk("gap_im5", im5, 64'h0013_0012_0011_0010);
    chk("gap_im10", im10, 64'h0027_0026_0025_0024);

    // Restart mid-load: 2 entries + 2 words of A, then start with in_valid high
    for (int k = 0; k < 40; k++) src[k] = WORD_W'($urandom);
    pulse_start(1'b0);
    load_words(10, 20);
    pulse_start(1'b1);
    chk("restart_idx", 64'(level_idx), 64'h0);
    chk("restart_im3_kept", im3, 64'h000b_000a_0009_0008);
    chk("restart_im1_a", im1, {src[3], src[2], src[1], src[0]});
    for (int k = 0; k < 40; k++) src[k] = WORD_W'($urandom);
    load_words(40, 30);
    chk("b_im10", im10, {src[39], src[38], src[37], src[36]});

    // Reset mid-load after 17 words
    pulse_start(1'b0);
    load_words(17, 0);
    #2 nrst = 1'b0;
    #1;
    chk("mrst_im1", im1, 64'h0);
    chk("mrst_im10", im10, 64'h0);
    chk("mrst_loaded", 64'(loaded), 64'h0);
    chk("mrst_busy", 64'(busy), 64'h0);
    chk("mrst_idx", 64'(level_idx), 64'h0);
    chk("mrst_ready", 64'(in_ready), 64'h0);
    in_valid = 1'b1;
    in_data  = WORD_W'($urandom);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    repeat (6) begin
      in_data = WORD_W'($urandom);
      @(posedge clk);
      #1;
    end
    chk("idle_valid_im1", im1, 64'h0);
    chk("idle_valid_busy", 64'(busy), 64'h0);
    in_valid = 1'b0;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Item-memory writer for the sparse HDC datapath. It accepts a stream of narrow words over a valid/ready handshake and assembles them into the ten 64-bit level hypervectors. It holds those hypervectors in registers that drive the `im1`..`im10` inputs of the level-HV fetch mux. It is the programming side of that fetch path: this block writes the item memory, the fetch mux reads it.

## Interface
Parameters:
- `HV_W`, 64, hypervector width in bits.
- `WORD_W`, 16, input word width. `HV_W` must be an integer multiple of `WORD_W`. `WPH = HV_W/WORD_W` (words per hypervector, 4 at the defaults).
- `NUM_LEVELS`, 10, number of level hypervectors. Fixed at 10 to match the ten `im` outputs.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `nrst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that begins or restarts programming.
- `in_data`, input, `WORD_W`: hypervector word.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: loader accepts a word this cycle.
- `im1`..`im10`, output, `HV_W` each: stored level hypervectors.
- `level_idx`, output, 4: index (0..9) of the entry currently being assembled.
- `busy`, output, 1: high while in LOAD.
- `loaded`, output, 1: all ten entries written since the last `start`.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`.
  - LOAD → DONE on acceptance of the final word (word `WPH-1` of entry 9).
  - DONE → LOAD on `start`.
  - `start` in LOAD restarts LOAD.
- Handshake:
  - `in_ready = (state==LOAD) && !start`. This is combinational.
  - A word is accepted on a rising edge where `in_valid && in_ready`.
  - `in_valid` in IDLE or DONE is ignored and has no effect.
- Counters:
  - `word_cnt`, 0..`WPH-1`, and `entry_cnt`, 0..9. `level_idx = entry_cnt`.
  - On acceptance, `word_cnt` increments.
  - At `WPH-1`, `word_cnt` wraps to 0 and `entry_cnt` increments.
  - At entry 9, word `WPH-1`, both counters clear and the FSM goes to DONE.
- Assembly order:
  - Word order is LSB first: word w lands in bits [w*WORD_W +: WORD_W].
  - Words are assembled in a `HV_W` staging register.
  - On acceptance of word `WPH-1`, the full entry (staging bits plus the current `in_data` in the top slice) is committed to `im[entry_cnt+1]` in a single edge. Entries are filled in order: `im1` first, `im10` last.
  - An `im` output never shows a partially written vector.
- `start` behaviour:
  - `start` clears `word_cnt`, `entry_cnt`, the staging register and `loaded`.
  - It does not clear `im1`..`im10`. Old contents persist until each entry is overwritten.
  - `start` in LOAD discards the partially assembled entry; no commit happens.
- `loaded` rises on the edge that commits `im10` and stays high until the next `start` or reset.
- `busy` is high whenever the FSM is in LOAD.
- Reset (`nrst` low), asynchronous, from any state, including mid-load:
  - FSM goes to IDLE.
  - Counters and staging register go to 0.
  - `im1`..`im10` go to 0.
  - `loaded`, `busy` and `level_idx` go to 0.
  - `in_ready` reads 0 while in reset.

## Timing
- `start` sampled at edge t: the FSM is in LOAD after t, so `in_ready` can be high from cycle t+1.
- Throughput: one word per cycle when `in_valid` is held high. A full load is `NUM_LEVELS*WPH` = 40 accepted words.
- Commit latency: the entry is visible on `im[n]` in the cycle after the edge that accepts its last word.
- `loaded` and the `im10` update become visible together after the 40th acceptance edge. From `start` to `loaded`, the minimum is 41 edges.
- Gaps in `in_valid` stall the counters. No state changes on non-accepting cycles.
- `start` and `in_valid` high in the same cycle: `start` wins. No word is accepted, because `in_ready` is 0.
- Reset deassertion is synchronised externally. The first active edge after release sees the FSM in IDLE.

## Test plan
- Reset check: assert `nrst`=0 mid-cycle → all `im*`, `loaded`, `busy`, `level_idx`, `in_ready` read 0 immediately, without waiting for a clock edge.
- Full load: `start`, then 40 back-to-back words, word k = 16'h0000+k → `im1`=64'h0003_0002_0001_0000 and `im10`=64'h0027_0026_0025_0024. `loaded` rises after edge 40, FSM is in DONE, `in_ready`=0.
- Backpressure and gaps: the same 40 words with random `in_valid` gaps → identical `im` contents. `level_idx` steps 0→9 only on the 4th accepted word of each entry.
- Restart mid-load:
  - Load 2 full entries plus 2 words (value A), then `start` with `in_valid`=1 in the same cycle → that word is not accepted.
  - `im1`/`im2` hold A until rewritten; `im3` keeps its pre-restart contents.
  - A fresh 40-word load (value B) → all entries hold B.
- Reload from DONE: after a full load, pulse `start` → `loaded`=0 on the next cycle. `im*` keep the old values until each entry is recommitted.
- Reset mid-load: `nrst` low after 17 accepted words → all outputs 0, FSM in IDLE. `in_valid` held high in IDLE, with no `start`, causes no changes.
